wptr_level_handler: RTL

//  Write-domain pointer controller for the async FIFO, successor to the basic write-pointer block.

---
 rtl/wptr_level_handler.sv | 99 +++++++++
 1 files changed

// File: rtl/wptr_level_handler.sv
// Write-domain pointer controller for an async FIFO.
// Keeps the binary write count and drives the Gray write pointer to the read side.
// It also produces the registered full, almost-full, level and sticky overflow flags
// from the synchronised read Gray pointer.
// Handshake: a write is accepted on a clock edge when winc=1 and wen=1 (wen = winc & ~full);
// when full, winc is ignored by the pointer and only sets the sticky overflow flag.
module wptr_level_handler #(
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             wresetn,
    input  logic             winc,
    input  logic [ASIZE:0]   wq2rptr,
    input  logic [ASIZE:0]   af_thresh,
    input  logic             ovf_clr,
    output logic             wen,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             full,
    output logic             almost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             overflow
);

    logic [ASIZE:0]   wbin_q, wbin_d;
    logic [ASIZE:0]   wptr_q, wptr_d;
    logic [ASIZE-1:0] waddr_q, waddr_d;
    logic [ASIZE:0]   wlevel_q, wlevel_d;
    logic             full_q, full_d;
    logic             almost_full_q, almost_full_d;
    logic             overflow_q, overflow_d;

    logic [ASIZE:0]   rbin;
    logic [ASIZE:0]   wgray_next;
    logic [ASIZE:0]   rgray_wrapped;

    // A write only happens while the registered full flag is low.
    assign wen = winc & ~full_q;

    // Convert the synchronised read Gray pointer to binary (prefix XOR from the MSB down).
    always_comb begin
        rbin = '0;
        rbin[ASIZE] = wq2rptr[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ wq2rptr[i];
        end
    end

    // Next-state computation for pointer, address, level and flags.
    always_comb begin
        wbin_d        = wbin_q + {{ASIZE{1'b0}}, wen};
        wgray_next    = wbin_d ^ (wbin_d >> 1);
        // Full when the write pointer is exactly one lap ahead of the read pointer:
        // in Gray code that is the read pointer with its top two bits inverted.
        rgray_wrapped = {~wq2rptr[ASIZE:ASIZE-1], wq2rptr[ASIZE-2:0]};
        wptr_d        = wgray_next;
        waddr_d       = wbin_d[ASIZE-1:0];
        full_d        = (wgray_next == rgray_wrapped);
        wlevel_d      = wbin_d - rbin;
        almost_full_d = (wlevel_d >= af_thresh);
        // Setting has priority over clearing so a same-cycle overflow is never lost.
        if (winc && full_q) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge wresetn) begin
        if (!wresetn) begin
            wbin_q        <= '0;
            wptr_q        <= '0;
            waddr_q       <= '0;
            wlevel_q      <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wbin_q        <= wbin_d;
            wptr_q        <= wptr_d;
            waddr_q       <= waddr_d;
            wlevel_q      <= wlevel_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    assign wptr        = wptr_q;
    assign waddr       = waddr_q;
    assign wlevel      = wlevel_q;
    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign overflow    = overflow_q;

endmodule
